// File: rtl/cpu_regbank_pkg.sv
// cpu_regbank_pkg: shared types and constants for the CPU register bank
package cpu_regbank_pkg;
   typedef enum logic [1:0] {WR_NONE = 2'd0, WR_BYTE = 2'd1, WR_PAIR = 2'd2} wr_mode_e;
   typedef enum logic [1:0] {DUMP_IDLE = 2'd0, DUMP_SEND = 2'd1, DUMP_DONE = 2'd2} dump_state_e;
   localparam int FLAG_Z = 7;
   localparam int FLAG_N = 6;
   localparam int FLAG_H = 5;
   localparam int FLAG_C = 4;
   localparam int REG_B = 0;
   localparam int REG_C = 1;
   localparam int REG_D = 2;
   localparam int REG_E = 3;
   localparam int REG_H = 4;
   localparam int REG_L = 5;
   localparam int REG_A = 6;
   localparam int REG_SP_H = 8;
   localparam int REG_SP_L = 9;
   localparam int REG_PC_H = 10;
   localparam int REG_PC_L = 11;
endpackage

// File: rtl/cpu_regbank_if.sv
// cpu_regbank_if: write/read/flag/step/shadow/dump bus of the register bank
interface cpu_regbank_if import cpu_regbank_pkg::*; #(parameter int DATA_W = 8, parameter int IDX_W = 4);
   wr_mode_e wr_mode;
   logic [IDX_W-1:0] wr_idx;
   logic [2*DATA_W-1:0] wr_data;
   logic [IDX_W-1:0] rd_idx1;
   logic [DATA_W-1:0] rd_hi1;
   logic [DATA_W-1:0] rd_lo1;
   logic [IDX_W-1:0] rd_idx2;
   logic [DATA_W-1:0] rd_hi2;
   logic [DATA_W-1:0] rd_lo2;
   logic [3:0] flag_mask;
   logic [3:0] flag_data;
   logic [7:0] flags;
   logic step_en;
   logic [IDX_W-1:0] step_idx;
   logic step_dec;
   logic shadow_save;
   logic shadow_restore;
   logic dump_start;
   logic dump_valid;
   logic dump_ready;
   logic [IDX_W-1:0] dump_idx;
   logic [DATA_W-1:0] dump_data;
   logic dump_busy;
   logic dump_done;
   modport master (
      output wr_mode, wr_idx, wr_data, rd_idx1, rd_idx2, flag_mask, flag_data,
             step_en, step_idx, step_dec, shadow_save, shadow_restore, dump_start, dump_ready,
      input  rd_hi1, rd_lo1, rd_hi2, rd_lo2, flags, dump_valid, dump_idx, dump_data, dump_busy, dump_done
   );
   modport slave (
      input  wr_mode, wr_idx, wr_data, rd_idx1, rd_idx2, flag_mask, flag_data,
             step_en, step_idx, step_dec, shadow_save, shadow_restore, dump_start, dump_ready,
      output rd_hi1, rd_lo1, rd_hi2, rd_lo2, flags, dump_valid, dump_idx, dump_data, dump_busy, dump_done
   );
endinterface

// File: rtl/cpu_regbank_dump.sv
// cpu_regbank_dump: handshaked dump engine walking regs 0..NUM_REGS-1 then flags
module cpu_regbank_dump import cpu_regbank_pkg::*; #(
   parameter int DATA_W = 8,
   parameter int NUM_REGS = 12,
   parameter int IDX_W = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic ready,
   input  logic [DATA_W-1:0] rd_data,
   output logic [IDX_W-1:0] rd_idx,
   output logic valid,
   output logic [IDX_W-1:0] idx,
   output logic [DATA_W-1:0] data,
   output logic busy,
   output logic done
);
   dump_state_e state, state_nxt;
   logic [IDX_W-1:0] ptr, ptr_nxt;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= DUMP_IDLE;
         ptr <= '0;
      end else begin
         state <= state_nxt;
         ptr <= ptr_nxt;
      end
   always_comb begin
      state_nxt = state == DUMP_IDLE ? (start ? DUMP_SEND : DUMP_IDLE) :
                  state == DUMP_SEND ? (ready && ptr == IDX_W'(NUM_REGS) ? DUMP_DONE : DUMP_SEND) : DUMP_IDLE;
      ptr_nxt = state == DUMP_SEND && ready ? ptr + IDX_W'(1) : state == DUMP_SEND ? ptr : '0;
   end
   assign rd_idx = ptr;
   assign valid = state == DUMP_SEND;
   assign idx = valid ? ptr : '0;
   assign data = valid ? rd_data : '0;
   assign busy = state != DUMP_IDLE;
   assign done = state == DUMP_DONE;
endmodule

// File: rtl/cpu_regbank.sv
// cpu_regbank: byte/pair register file with flags, pair stepping, shadow bank and debug dump
module cpu_regbank import cpu_regbank_pkg::*; #(
   parameter int DATA_W = 8,
   parameter int NUM_REGS = 12,
   parameter int IDX_W = $clog2(NUM_REGS + 1),
   parameter int BYPASS = 1
) (
   input logic clk,
   input logic rst,
   cpu_regbank_if.slave bus
);
   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] shadow [NUM_REGS];
   logic [DATA_W-1:0] wd [NUM_REGS];
   logic [DATA_W-1:0] view [NUM_REGS+1];
   logic [3:0] flag_r, shadow_flag;
   logic [NUM_REGS-1:0] we, step_sel;
   logic [2*DATA_W-1:0] step_pair, step_val;
   logic step_go;
   logic [IDX_W-1:0] wr_lo, dump_ptr;
   logic [DATA_W-1:0] dump_rdata;
   function automatic logic [IDX_W-1:0] hi_of(input logic [IDX_W-1:0] i);
      return i >= IDX_W'(NUM_REGS) ? IDX_W'(NUM_REGS) : i;
   endfunction
   function automatic logic [IDX_W-1:0] lo_of(input logic [IDX_W-1:0] i);
      return i >= IDX_W'(NUM_REGS) ? IDX_W'(NUM_REGS) : i == IDX_W'(NUM_REGS - 1) ? '0 : i + IDX_W'(1);
   endfunction
   assign wr_lo = lo_of(bus.wr_idx);
   always_comb begin
      we = '0;
      step_sel = '0;
      step_pair = '0;
      view[NUM_REGS] = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         we[r] = !bus.shadow_restore && bus.wr_idx < IDX_W'(NUM_REGS) &&
                 (((bus.wr_mode == WR_BYTE || bus.wr_mode == WR_PAIR) && bus.wr_idx == IDX_W'(r)) ||
                  (bus.wr_mode == WR_PAIR && wr_lo == IDX_W'(r)));
         wd[r] = bus.wr_mode == WR_PAIR && bus.wr_idx == IDX_W'(r) ? bus.wr_data[2*DATA_W-1:DATA_W] : bus.wr_data[DATA_W-1:0];
         view[r] = BYPASS != 0 && we[r] ? wd[r] : regs[r];
         step_sel[r] = bus.step_idx == IDX_W'(r) || bus.step_idx + IDX_W'(1) == IDX_W'(r);
         if (bus.step_idx == IDX_W'(r)) step_pair[2*DATA_W-1:DATA_W] = regs[r];
         if (bus.step_idx + IDX_W'(1) == IDX_W'(r)) step_pair[DATA_W-1:0] = regs[r];
      end
      step_go = bus.step_en && !bus.shadow_restore && !bus.step_idx[0] &&
                bus.step_idx < IDX_W'(NUM_REGS) && !(|(we & step_sel));
      step_val = bus.step_dec ? step_pair - (2*DATA_W)'(1) : step_pair + (2*DATA_W)'(1);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         regs <= '{default: '0};
         shadow <= '{default: '0};
         flag_r <= '0;
         shadow_flag <= '0;
      end else begin
         if (bus.shadow_restore) begin
            regs <= shadow;
            flag_r <= shadow_flag;
         end else begin
            for (int r = 0; r < NUM_REGS; r++)
               regs[r] <= we[r] ? wd[r] :
                          step_go && step_sel[r] ? (bus.step_idx == IDX_W'(r) ? step_val[2*DATA_W-1:DATA_W] : step_val[DATA_W-1:0]) :
                          regs[r];
            flag_r <= (bus.flag_data & bus.flag_mask) | (flag_r & ~bus.flag_mask);
         end
         if (bus.shadow_save && !bus.shadow_restore) begin
            shadow <= regs;
            shadow_flag <= flag_r;
         end
      end
   assign bus.rd_hi1 = view[hi_of(bus.rd_idx1)];
   assign bus.rd_lo1 = view[lo_of(bus.rd_idx1)];
   assign bus.rd_hi2 = view[hi_of(bus.rd_idx2)];
   assign bus.rd_lo2 = view[lo_of(bus.rd_idx2)];
   assign bus.flags = {flag_r, 4'b0000};
   assign dump_rdata = dump_ptr < IDX_W'(NUM_REGS) ? regs[dump_ptr] : DATA_W'({flag_r, 4'b0000});
   cpu_regbank_dump #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_dump (
      .clk(clk),
      .rst(rst),
      .start(bus.dump_start),
      .ready(bus.dump_ready),
      .rd_data(dump_rdata),
      .rd_idx(dump_ptr),
      .valid(bus.dump_valid),
      .idx(bus.dump_idx),
      .data(bus.dump_data),
      .busy(bus.dump_busy),
      .done(bus.dump_done)
   );
endmodule

// File: doc/cpu_regbank.md
Name: cpu_regbank

Overview:
Parametrised successor to the CPU byte register file. Holds NUM_REGS byte registers, addressed singly or as even/odd 16-bit pairs, plus a separate flag register with per-bit masked writes. Adds a pair increment/decrement port for HL+/HL-/SP/PC stepping, optional write-to-read bypass, a one-deep shadow bank for interrupt save/restore, and a handshaked debug dump engine. Sits between decode/ALU and the datapath muxes in the CPU core.

Parameters:
DATA_W, 8, byte register width; pair width is 2*DATA_W
NUM_REGS, 12, number of byte registers; must be even and >= 2
IDX_W, $clog2(NUM_REGS+1), index width; sized so flags can be dump index NUM_REGS
BYPASS, 1, 1 = reads forward same-cycle main-port write data; 0 = registered-only reads

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-high
wr_mode  in  2  0 none, 1 byte, 2 pair, 3 none (reserved)
wr_idx  in  IDX_W  byte target, or high byte of pair
wr_data  in  2*DATA_W  byte mode uses [DATA_W-1:0]; pair mode high to wr_idx, low to wr_idx+1
rd_idx1  in  IDX_W  read port 1 index
rd_hi1  out  DATA_W  regs[rd_idx1]
rd_lo1  out  DATA_W  regs[(rd_idx1+1) mod NUM_REGS]
rd_idx2  in  IDX_W  read port 2 index
rd_hi2  out  DATA_W  regs[rd_idx2]
rd_lo2  out  DATA_W  regs[(rd_idx2+1) mod NUM_REGS]
flag_mask  in  4  per-bit write enable for Z,N,H,C
flag_data  in  4  new Z,N,H,C values
flags  out  8  {Z,N,H,C,4'b0}
step_en  in  1  increment/decrement a pair
step_idx  in  IDX_W  pair high-byte index; must be even
step_dec  in  1  0 = +1, 1 = -1 (16-bit, wraps)
shadow_save  in  1  copy regs+flags into shadow bank
shadow_restore  in  1  copy shadow bank into regs+flags
dump_start  in  1  start debug dump
dump_valid  out  1  dump beat valid
dump_ready  in  1  consumer accepts beat
dump_idx  out  IDX_W  index of current beat (NUM_REGS = flags)
dump_data  out  DATA_W  value of current beat
dump_busy  out  1  dump engine not idle
dump_done  out  1  one-cycle pulse after final beat accepted

Behaviour:
- Reset: all regs, flags, shadow bank = 0; dump FSM IDLE; dump_valid, dump_busy, dump_done = 0; dump_idx, dump_data = 0.
- Reads combinational. Pair low byte index wraps: idx NUM_REGS-1 pairs with 0. Pair writes wrap identically. Indices >= NUM_REGS on read return 0; writes to them are ignored.
- BYPASS=1: any read byte whose index equals a byte written this cycle by the main port returns the incoming value. Step, flag and restore results are not forwarded; they are visible the next cycle.
- Step: {regs[i],regs[i+1]} +/- 1 mod 2^(2*DATA_W). 0xFFFF+1 -> 0x0000, 0x0000-1 -> 0xFFFF. An odd step_idx is ignored (no-op).
- Priority per cycle: shadow_restore > main write > step. Restore suppresses main write, step and flag write that cycle. If the step pair overlaps any byte written by the main port, the whole step is dropped.
- shadow_save and shadow_restore together: restore wins, and the shadow bank is unchanged. Save captures pre-edge values, ignoring writes in the same cycle.
- Flag write: flags[7-k] <= flag_data[3-k] where flag_mask[3-k]=1. Low nibble is always 0.
- Dump FSM:
  - IDLE: dump_start -> SEND, ptr=0.
  - SEND: dump_valid=1, dump_idx=ptr, dump_data=live regs[ptr] (flags when ptr=NUM_REGS).
  - Transfer = valid&&ready. On transfer, ptr++. Transfer at ptr=NUM_REGS -> DONE.
  - DONE: dump_done=1 for one cycle -> IDLE.
  - dump_busy=1 in SEND and DONE. dump_start is ignored unless in IDLE.
  - dump_data is live, not a snapshot. Writes during a dump are legal, and subsequent beats reflect them.
  - Holding dump_ready=0 stalls indefinitely with dump_idx and dump_data tracking live contents.
  - Asynchronous rst mid-dump forces IDLE immediately.

Decomposition:
- Shared package cpu_regbank_pkg holds:
  - wr_mode enum (WR_NONE, WR_BYTE, WR_PAIR).
  - Flag bit positions (FLAG_Z=7, FLAG_N=6, FLAG_H=5, FLAG_C=4).
  - Dump state enum (DUMP_IDLE, DUMP_SEND, DUMP_DONE).
  - Canonical register index constants (B=0, C=1, D=2, E=3, H=4, L=5, A=6, SP_H=8, SP_L=9, PC_H=10, PC_L=11).
- One sub-module: cpu_regbank_dump, the dump FSM plus pointer. It is given a read index and returns data via a third internal read port.

Test Plan:
- Reset, then wr_mode=2, wr_idx=4, wr_data=0xC0DE -> next cycle rd_idx1=4 gives rd_hi1=0xC0, rd_lo1=0xDE. With BYPASS=1 the same values appear in the write cycle.
- Pair write 0xFFFF at idx 4, then step_en, step_idx=4, step_dec=0 -> pair reads 0x0000. Then step_dec=1 -> pair reads 0xFFFF.
- Same cycle: byte write 0x55 to idx 5 and step on pair 4 -> regs[5]=0x55, regs[4] unchanged (step dropped).
- flags=0xF0; flag_mask=4'b0101, flag_data=4'b0000 -> flags=0xA0. Then shadow_save; set A=0x12; shadow_restore -> A and flags return to their saved values, and a flag write in the restore cycle is ignored.
- Pair write at idx NUM_REGS-1=11 with 0xAB01 -> regs[11]=0xAB, regs[0]=0x01; rd_idx1=11 reads rd_lo1=0x01.
- dump_start with dump_ready toggling 1,0,1 -> 13 beats, idx 0..12, last beat equals flags; dump_done pulses once; a second dump_start while busy is ignored; rst asserted mid-dump -> dump_valid=0 immediately.
